tpose_row_sched: RTL and testbench



---
 rtl/tpose_pkg.sv | 17 +
 rtl/tpose_credit_ctr.sv | 32 +++
 rtl/tpose_row_sched.sv | 136 +++++++++++++
 tb/tb_tpose_row_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpose_pkg.sv
// Shared defaults and state encoding for the transpose-page row scheduler.
package tpose_pkg;

    localparam int unsigned W_DEF            = 16;
    localparam int unsigned LANES_DEF        = 8;
    localparam int unsigned ROWS_PER_BLK_DEF = 8;
    localparam int unsigned CREDIT_ROWS_DEF  = 16;
    localparam int unsigned BLK_W            = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/tpose_credit_ctr.sv
// Saturating up/down count of rows accepted by the page but not yet retired.
module tpose_credit_ctr #(
    parameter int unsigned MAX = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(MAX+1)-1:0]     count,
    output logic                         full,
    output logic                         empty,
    output logic                         underflow
);

    localparam int unsigned CW = $clog2(MAX + 1);

    assign full      = (count == CW'(MAX));
    assign empty     = (count == '0);
    assign underflow = dec & empty;

    // Simultaneous inc and dec cancel; each direction saturates at its bound.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + CW'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/tpose_row_sched.sv
// Fires full lane-aligned rows into the transpose page under a row credit limit,
// counts completed blocks and enforces lane-synchronous end-of-stream.
module tpose_row_sched
    import tpose_pkg::*;
#(
    parameter int unsigned W            = W_DEF,
    parameter int unsigned LANES        = LANES_DEF,
    parameter int unsigned ROWS_PER_BLK = ROWS_PER_BLK_DEF,
    parameter int unsigned CREDIT_ROWS  = CREDIT_ROWS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [LANES*W-1:0]   up_d,
    input  logic [LANES-1:0]     up_e,
    input  logic [LANES-1:0]     up_v,
    output logic [LANES-1:0]     up_b,
    output logic [LANES*W-1:0]   pg_d,
    output logic [LANES-1:0]     pg_e,
    output logic [LANES-1:0]     pg_v,
    input  logic [LANES-1:0]     pg_b,
    input  logic                 mon_v,
    input  logic                 mon_b,
    output logic [BLK_W-1:0]     blk_count,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned RW = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1;
    localparam int unsigned CW = $clog2(CREDIT_ROWS + 1);

    state_t          state_q;
    state_t          state_d;
    logic [RW-1:0]   row_cnt;
    logic [CW-1:0]   in_flight;
    logic            full;
    logic            empty;
    logic            underflow;
    logic            all_v;
    logic            any_e;
    logic            all_e;
    logic            pg_free;
    logic            row_zero;
    logic            row_last;
    logic            retire;
    logic            data_fire;
    logic            eos_fire;
    logic            fire;

    assign pg_d     = up_d;
    assign pg_e     = up_e;

    assign all_v    = &up_v;
    assign any_e    = |(up_e & up_v);
    assign all_e    = &up_e;
    assign pg_free  = ~|pg_b;
    assign row_zero = (row_cnt == '0);
    assign row_last = (row_cnt == RW'(ROWS_PER_BLK - 1));
    assign retire   = mon_v & ~mon_b;

    tpose_credit_ctr #(
        .MAX       (CREDIT_ROWS)
    ) u_credit (
        .clock     (clock),
        .reset     (reset),
        .inc       (data_fire),
        .dec       (retire),
        .count     (in_flight),
        .full      (full),
        .empty     (empty),
        .underflow (underflow)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and fire decisions; credit check uses the registered count
    always_comb begin
        state_d   = state_q;
        data_fire = 1'b0;
        eos_fire  = 1'b0;
        case (state_q)
            RUN: begin
                data_fire = all_v & ~any_e & pg_free & ~full;
                eos_fire  = all_v & all_e & row_zero & pg_free;
                if (underflow || (all_v && any_e && !all_e) || (all_v && all_e && !row_zero)) begin
                    state_d = ERR;
                end else if (eos_fire) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Enter DONE on the edge that retires the last row so done follows it by one cycle.
                if (underflow) begin
                    state_d = ERR;
                end else if (empty || (in_flight == CW'(1) && retire)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign fire = data_fire | eos_fire;
    assign pg_v = {LANES{fire}};
    assign up_b = {LANES{~fire}};

    // Row position, block count and status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt   <= '0;
            blk_count <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (data_fire) begin
                if (row_last) begin
                    row_cnt   <= '0;
                    blk_count <= blk_count + BLK_W'(1);
                end else begin
                    row_cnt   <= row_cnt + RW'(1);
                end
            end
            done <= (state_d == DONE);
            err  <= (state_d == ERR);
        end
    end

endmodule

// File: tb/tb_tpose_row_sched.sv
// Directed bench for tpose_row_sched: block counting, lane gating, credits, eos drain and errors.
module tb_tpose_row_sched;
    import tpose_pkg::*;

    localparam int unsigned W     = 16;
    localparam int unsigned LANES = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [LANES*W-1:0]   up_d;
    logic [LANES-1:0]     up_e;
    logic [LANES-1:0]     up_v;
    logic [LANES-1:0]     up_b;
    logic [LANES*W-1:0]   pg_d;
    logic [LANES-1:0]     pg_e;
    logic [LANES-1:0]     pg_v;
    logic [LANES-1:0]     pg_b;
    logic                 mon_v;
    logic                 mon_b;
    logic [15:0]          blk_count;
    logic                 done;
    logic                 err;

    int checks   = 0;
    int failures = 0;

    tpose_row_sched dut (
        .clock     (clock),
        .reset     (reset),
        .up_d      (up_d),
        .up_e      (up_e),
        .up_v      (up_v),
        .up_b      (up_b),
        .pg_d      (pg_d),
        .pg_e      (pg_e),
        .pg_v      (pg_v),
        .pg_b      (pg_b),
        .mon_v     (mon_v),
        .mon_b     (mon_b),
        .blk_count (blk_count),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        up_v  = '0;
        up_e  = '0;
        mon_v = 1'b0;
        mon_b = 1'b0;
        pg_b  = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Offer n data rows back to back; each must fire in its own cycle.
    task automatic send_rows(input int n);
        logic [LANES*W-1:0] d;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < LANES; l++) d[l*W +: W] = W'(16'h100 * l + i);
            up_d = d;
            up_v = '1;
            up_e = '0;
            #2;
            check("row_fire", pg_v, 8'hFF);
            check("row_data", pg_d, d);
            tick();
        end
        idle();
    endtask

    initial begin
        up_d = '0;
        do_reset();
        #2;
        check("rst_up_b", up_b, 8'hFF);
        check("rst_pg_v", pg_v, 8'h00);
        check("rst_blk", blk_count, 16'd0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_inflight", dut.u_credit.count, 0);

        // One full block
        send_rows(8);
        #2;
        check("blk1_count", blk_count, 16'd1);
        check("blk1_inflight", dut.u_credit.count, 8);
        check("blk1_row", dut.row_cnt, 0);

        // Page backpressure on one lane holds the row
        up_v = '1;
        pg_b = 8'h04;
        #2;
        check("pgb_pg_v", pg_v, 8'h00);
        check("pgb_up_b", up_b, 8'hFF);
        tick();
        idle();

        // Lane 7 late for 5 cycles
        for (int i = 0; i < 5; i++) begin
            up_v = 8'h7F;
            #2;
            check("lane7_pg_v", pg_v, 8'h00);
            check("lane7_up_b", up_b, 8'hFF);
            tick();
        end
        up_v = 8'hFF;
        #2;
        check("lane7_fire", pg_v, 8'hFF);
        check("lane7_up_b_open", up_b, 8'h00);
        tick();
        idle();
        #2;
        check("lane7_inflight", dut.u_credit.count, 9);
        check("lane7_row", dut.row_cnt, 1);

        // Fill credits, hold the 17th row, release with one retire
        send_rows(7);
        #2;
        check("cred_inflight", dut.u_credit.count, 16);
        check("cred_blk", blk_count, 16'd2);
        up_v  = '1;
        #2;
        check("cred_hold", pg_v, 8'h00);
        mon_v = 1'b1;
        mon_b = 1'b1;
        tick();
        #2;
        check("cred_monb_hold", pg_v, 8'h00);
        check("cred_monb_inflight", dut.u_credit.count, 16);
        mon_b = 1'b0;
        #2;
        check("cred_retire_cycle", pg_v, 8'h00);
        tick();
        mon_v = 1'b0;
        #2;
        check("cred_after_retire", dut.u_credit.count, 15);
        check("cred_resume", pg_v, 8'hFF);
        tick();
        idle();
        #2;
        check("cred_final", dut.u_credit.count, 16);
        check("cred_row", dut.row_cnt, 1);
        check("cred_err", err, 1'b0);

        // Two blocks then eos, drain by 16 retires
        do_reset();
        send_rows(16);
        #2;
        check("eos_pre_blk", blk_count, 16'd2);
        up_v = '1;
        up_e = '1;
        #2;
        check("eos_fire", pg_v, 8'hFF);
        check("eos_fwd", pg_e, 8'hFF);
        tick();
        up_e = '0;
        for (int i = 0; i < 16; i++) begin
            mon_v = 1'b1;
            #2;
            check("drain_block", up_b, 8'hFF);
            check("drain_done", done, 1'b0);
            tick();
        end
        mon_v = 1'b0;
        #2;
        check("done_set", done, 1'b1);
        check("done_inflight", dut.u_credit.count, 0);
        check("done_up_b", up_b, 8'hFF);
        check("done_err", err, 1'b0);
        check("done_blk", blk_count, 16'd2);
        tick();
        #2;
        check("done_hold", done, 1'b1);
        do_reset();
        #2;
        check("rst2_blk", blk_count, 16'd0);
        check("rst2_done", done, 1'b0);

        // Mixed eos across lanes
        send_rows(3);
        up_v = '1;
        up_e = 8'h08;
        #2;
        check("mixed_no_fire", pg_v, 8'h00);
        tick();
        #2;
        check("mixed_err", err, 1'b1);
        check("mixed_up_b", up_b, 8'hFF);
        do_reset();
        #2;
        check("rst3_err", err, 1'b0);
        check("rst3_blk", blk_count, 16'd0);

        // Eos row mid-block
        send_rows(3);
        up_v = '1;
        up_e = '1;
        #2;
        check("midblk_no_fire", pg_v, 8'h00);
        tick();
        idle();
        #2;
        check("midblk_err", err, 1'b1);

        // Retire with nothing in flight
        do_reset();
        mon_v = 1'b1;
        tick();
        mon_v = 1'b0;
        #2;
        check("underflow_err", err, 1'b1);
        check("underflow_up_b", up_b, 8'hFF);

        // Retire coincident with a data fire leaves the count alone
        do_reset();
        send_rows(5);
        up_v  = '1;
        mon_v = 1'b1;
        #2;
        check("coinc_fire", pg_v, 8'hFF);
        tick();
        idle();
        #2;
        check("coinc_inflight", dut.u_credit.count, 5);
        check("coinc_err", err, 1'b0);
        check("coinc_row", dut.row_cnt, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
